hazard_forward_ctrl: RTL

- Sequential hazard/forwarding controller for the 5-stage RISC-V pipeline.
- Produces the select lines that drive the 32-bit 2:1 and 3:1 operand muxes in EX and the regfile bypass muxes in ID.
- Keeps its own shadow copy of in-flight register metadata (EX, MEM, WB slots). It detects load-use hazards, stalls and inserts bubbles, and counts stall cycles for performance monitoring.

---
 rtl/hazard_forward_ctrl_if.sv | 48 ++++
 rtl/hazard_forward_ctrl.sv | 120 ++++++++++++
 2 files changed

// File: rtl/hazard_forward_ctrl_if.sv
// hazard_forward_ctrl_if
//   Bundles the ID-stage register metadata, the control inputs and the
//   controller's select/stall outputs for the 5-stage RISC-V pipeline.
//
//   Signals:
//     id_valid, id_rs1, id_rs2, id_rd    ID instruction and its registers
//     id_reg_write, id_mem_read          ID instruction writes rd / is a load
//     flush_ex                           taken branch/jump squashes ID
//     cnt_clear                          synchronous clear of stall counter
//     stall                              hold PC and IF/ID
//     fwd_a, fwd_b                       EX operand selects (00 rf, 01 WB, 10 MEM)
//     id_byp_a, id_byp_b                 ID regfile read bypassed from WB
//     stall_count                        saturating stall-cycle counter
//
//   Modports:
//     master  pipeline side: drives ID metadata and controls
//     slave   controller side: consumes them, drives selects and stall
interface hazard_forward_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic [REG_AW-1:0] id_rd;
  logic              id_reg_write;
  logic              id_mem_read;
  logic              flush_ex;
  logic              cnt_clear;
  logic              stall;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic              id_byp_a;
  logic              id_byp_b;
  logic [CNT_W-1:0]  stall_count;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, id_reg_write, id_mem_read,
           flush_ex, cnt_clear,
    input  stall, fwd_a, fwd_b, id_byp_a, id_byp_b, stall_count
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd, id_reg_write, id_mem_read,
           flush_ex, cnt_clear,
    output stall, fwd_a, fwd_b, id_byp_a, id_byp_b, stall_count
  );
endinterface

// File: rtl/hazard_forward_ctrl.sv
// hazard_forward_ctrl
//   Hazard detection and forwarding controller for a 5-stage RISC-V pipeline.
//   Tracks a shadow copy of the register metadata of the instructions in
//   EX, MEM and WB, raises a one-cycle stall on a load-use dependency
//   (inserting a bubble into EX), generates the EX operand forwarding
//   selects and the ID regfile bypass selects, and counts stall cycles in a
//   saturating counter.
//
//   Ports:
//     clk   system clock, rising edge
//     rst   asynchronous active-high reset
//     bus   hazard_forward_ctrl_if.slave (ID metadata in, selects/stall out)
module hazard_forward_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  hazard_forward_ctrl_if.slave  bus
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic              rw;
    logic              mr;
  } slot_t;

  localparam slot_t BUBBLE = '0;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  slot_t            ex_q;
  slot_t            mem_q;
  slot_t            wb_q;
  slot_t            id_slot;
  logic             stall_w;
  logic [CNT_W-1:0] count_q;

  // WB is only a forwarding/bypass source; its remaining fields are carried
  // along for debug visibility but do not feed any decision.
  logic unused_wb_fields;
  assign unused_wb_fields = ^{wb_q.valid, wb_q.rs1, wb_q.rs2, wb_q.mr};

  // Metadata the ID instruction would carry into EX; write/load flags are
  // qualified by valid so an empty slot can never look like a producer.
  always_comb begin
    id_slot       = BUBBLE;
    id_slot.valid = bus.id_valid;
    id_slot.rs1   = bus.id_rs1;
    id_slot.rs2   = bus.id_rs2;
    id_slot.rd    = bus.id_rd;
    id_slot.rw    = bus.id_reg_write & bus.id_valid;
    id_slot.mr    = bus.id_mem_read & bus.id_valid;
  end

  // Load-use: the load in EX has not produced data yet, so a dependent ID
  // instruction must wait one cycle. A squashed ID instruction never stalls.
  always_comb begin
    stall_w = ex_q.mr && (ex_q.rd != '0) && bus.id_valid && !bus.flush_ex &&
              ((ex_q.rd == bus.id_rs1) || (ex_q.rd == bus.id_rs2));
  end

  // Operand selects: the younger producer in MEM wins over WB.
  always_comb begin
    bus.fwd_a = 2'b00;
    bus.fwd_b = 2'b00;
    if (mem_q.rw && (mem_q.rd != '0) && (mem_q.rd == ex_q.rs1)) begin
      bus.fwd_a = 2'b10;
    end else if (wb_q.rw && (wb_q.rd != '0) && (wb_q.rd == ex_q.rs1)) begin
      bus.fwd_a = 2'b01;
    end
    if (mem_q.rw && (mem_q.rd != '0) && (mem_q.rd == ex_q.rs2)) begin
      bus.fwd_b = 2'b10;
    end else if (wb_q.rw && (wb_q.rd != '0) && (wb_q.rd == ex_q.rs2)) begin
      bus.fwd_b = 2'b01;
    end
  end

  // The regfile is written at the end of the cycle, so a same-cycle read in
  // ID must take the WB write data directly.
  always_comb begin
    bus.id_byp_a = wb_q.rw && (wb_q.rd != '0) && (wb_q.rd == bus.id_rs1);
    bus.id_byp_b = wb_q.rw && (wb_q.rd != '0) && (wb_q.rd == bus.id_rs2);
  end

  assign bus.stall       = stall_w;
  assign bus.stall_count = count_q;

  // Slot pipeline: MEM and WB always advance; EX takes a bubble when the ID
  // instruction is squashed or held back by a stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q  <= BUBBLE;
      mem_q <= BUBBLE;
      wb_q  <= BUBBLE;
    end else begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      if (bus.flush_ex || stall_w) begin
        ex_q <= BUBBLE;
      end else begin
        ex_q <= id_slot;
      end
    end
  end

  // Stall-cycle counter: clear beats increment, and it sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (bus.cnt_clear) begin
      count_q <= '0;
    end else if (stall_w && (count_q != CNT_MAX)) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

endmodule
